// File: rtl/ppfifo_pkg.sv
// Shared definitions for the ping-pong FIFO stream writer: FSM encoding,
// count width and the buffer-select rule.
package ppfifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int COUNT_W = 24;

  // Returns the buffer index to own next; alternates when both buffers are free.
  function automatic logic pick_buffer(input logic [1:0] ready, input logic last_sel);
    if (ready == 2'b11) return ~last_sel;
    return ready[1];
  endfunction

endpackage

// File: rtl/ppfifo_stream_writer.sv
// Valid/ready stream feeder for the ppfifo write port: owns one buffer at a time
// and releases it on fill, end-of-packet, flush or idle timeout.
module ppfifo_stream_writer
  import ppfifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  flush,
  input  logic [1:0]            write_ready,
  output logic [1:0]            write_activate,
  input  logic [COUNT_W-1:0]    write_fifo_size,
  output logic                  write_strobe,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  busy,
  output logic [31:0]           blocks_written
);

  localparam logic [31:0] TO_M1 = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_last_sel;
  logic [COUNT_W-1:0]   r_size;
  logic [COUNT_W-1:0]   r_count;
  logic [31:0]          r_idle_cnt;
  logic                 w_accept;
  logic                 w_grab;
  logic                 w_close;
  logic                 w_sel;
  logic [COUNT_W-1:0]   w_count_inc;

  assign busy = (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_accept    = 1'b0;
    w_grab      = 1'b0;
    w_close     = 1'b0;
    w_sel       = pick_buffer(write_ready, r_last_sel);
    w_count_inc = r_count + 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && (write_ready != 2'b00) && (write_activate == 2'b00)) begin
          w_grab      = 1'b1;
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        in_ready = (r_count < r_size);
        w_accept = in_valid && in_ready;
        if (w_accept && ((w_count_inc == r_size) || in_last)) w_close = 1'b1;
        // A flush arriving with a word still counts that word before releasing.
        if (flush && ((r_count != '0) || w_accept)) w_close = 1'b1;
        if ((TIMEOUT != 0) && (r_idle_cnt == TO_M1) && (r_count != '0)) w_close = 1'b1;
        if (w_close) w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_activate <= 2'b00;
      write_strobe   <= 1'b0;
      write_data     <= '0;
      blocks_written <= 32'd0;
      r_last_sel     <= 1'b1;
      r_size         <= '0;
      r_count        <= '0;
      r_idle_cnt     <= 32'd0;
    end else begin
      write_strobe <= w_accept;
      if (w_accept) write_data <= in_data;

      if (w_grab) begin
        write_activate <= w_sel ? 2'b10 : 2'b01;
        r_size         <= (write_fifo_size == '0) ? COUNT_W'(1) : write_fifo_size;
        r_count        <= '0;
        r_idle_cnt     <= 32'd0;
        r_last_sel     <= w_sel;
      end

      if (r_state == ST_WRITE) begin
        if (w_accept) begin
          r_count    <= w_count_inc;
          r_idle_cnt <= 32'd0;
        end else if ((r_count != '0) && (r_idle_cnt != 32'hFFFF_FFFF)) begin
          r_idle_cnt <= r_idle_cnt + 32'd1;
        end
      end

      // Activate is held through the release cycle so the last registered strobe lands.
      if (r_state == ST_RELEASE) begin
        write_activate <= 2'b00;
        blocks_written <= blocks_written + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ppfifo_stream_writer.sv
// Bench for ppfifo_stream_writer: directed scenarios plus random traffic, all
// checked cycle by cycle against a buffer-ownership reference model.
module tb_ppfifo_stream_writer;

  localparam int DW  = 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          flush;
  logic [1:0]    write_ready;
  logic [1:0]    write_activate;
  logic [23:0]   write_fifo_size;
  logic          write_strobe;
  logic [DW-1:0] write_data;
  logic          busy;
  logic [31:0]   blocks_written;

  always #5 clk = ~clk;

  ppfifo_stream_writer #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .flush(flush), .write_ready(write_ready),
    .write_activate(write_activate), .write_fifo_size(write_fifo_size),
    .write_strobe(write_strobe), .write_data(write_data), .busy(busy),
    .blocks_written(blocks_written)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which buffer is owned, how full it is, and whether it is closing.
  int          m_own;
  bit          m_closing;
  bit          m_last;
  int          m_cap, m_fill, m_idle;
  int unsigned m_blocks;
  bit          m_strobe;
  logic [DW-1:0] m_data;
  bit          m_accept;

  logic [1:0]  grab_log[$];
  logic [1:0]  prev_act = 2'b00;
  int          strobes_seen = 0;

  function automatic void model_reset();
    m_own = -1; m_closing = 0; m_last = 1; m_cap = 0; m_fill = 0; m_idle = 0;
    m_blocks = 0; m_strobe = 0; m_data = '0;
  endfunction

  function automatic void model_advance();
    int fill_before, idle_before, pick;
    bit done;
    if (rst) begin
      model_reset();
      return;
    end
    m_strobe = m_accept;
    if (m_accept) m_data = in_data;
    if (m_own < 0) begin
      if (in_valid && write_ready != 2'b00) begin
        if (write_ready == 2'b11) pick = m_last ? 0 : 1;
        else                      pick = write_ready[1] ? 1 : 0;
        m_own = pick; m_last = pick[0];
        m_cap = (write_fifo_size == 0) ? 1 : int'(write_fifo_size);
        m_fill = 0; m_idle = 0;
      end
    end else if (m_closing) begin
      m_own = -1; m_closing = 0; m_blocks++;
    end else begin
      fill_before = m_fill; idle_before = m_idle; done = 0;
      if (m_accept) begin
        m_fill++; m_idle = 0;
        if (m_fill == m_cap || in_last) done = 1;
      end else if (fill_before > 0) begin
        m_idle++;
      end
      if (flush && m_fill > 0) done = 1;
      if (TMO != 0 && idle_before == TMO - 1 && fill_before > 0) done = 1;
      m_closing = done;
    end
  endfunction

  task automatic step();
    bit         exp_rdy;
    logic [1:0] exp_act;
    #1;
    exp_rdy = (m_own >= 0) && !m_closing && (m_fill < m_cap);
    exp_act = (m_own < 0) ? 2'b00 : ((m_own == 1) ? 2'b10 : 2'b01);
    check_eq("in_ready", in_ready, exp_rdy);
    check_eq("write_activate", write_activate, exp_act);
    check_eq("write_strobe", write_strobe, m_strobe);
    check_eq("write_data", write_data, m_data);
    check_eq("busy", busy, m_own >= 0);
    check_eq("blocks_written", blocks_written, m_blocks);
    if (write_activate != 2'b00 && prev_act == 2'b00) grab_log.push_back(write_activate);
    prev_act = write_activate;
    if (write_strobe) strobes_seen++;
    m_accept = in_valid && exp_rdy;
    model_advance();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_steps(input int n);
    in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_words(input int n, input bit last_on_final);
    int sent = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && sent < n; i++) begin
      in_data = DW'($urandom);
      in_last = last_on_final && (sent == n - 1);
      step();
      if (m_accept) sent++;
    end
    if (sent != n) check_eq("send_bound", sent, n);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
    step();
    rst = 1'b0;
    grab_log.delete();
    strobes_seen = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int hold;
    int pct;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; flush = 1'b0;
    write_ready = 2'b11; write_fifo_size = 24'd4;
    model_reset();
    @(posedge clk); #2;

    // Reset state
    do_reset();
    check_eq("rst_act", write_activate, 2'b00);
    check_eq("rst_blocks", blocks_written, 0);

    // 1: size 4, 10 words -> 4, 4, then 2 on timeout, ping-pong 0,1,0
    write_fifo_size = 24'd4; write_ready = 2'b11;
    send_words(10, 1'b0);
    idle_steps(40);
    check_eq("t1_blocks", blocks_written, 3);
    check_eq("t1_strobes", strobes_seen, 10);
    check_eq("t1_ngrab", grab_log.size(), 3);
    if (grab_log.size() == 3) begin
      check_eq("t1_grab0", grab_log[0], 2'b01);
      check_eq("t1_grab1", grab_log[1], 2'b10);
      check_eq("t1_grab2", grab_log[2], 2'b01);
    end

    // 2: 3 words with last on the third, size 16
    do_reset();
    write_fifo_size = 24'd16;
    send_words(3, 1'b1);
    check_eq("t2_release_hold", write_activate, 2'b01);
    step();
    check_eq("t2_drop", write_activate, 2'b00);
    idle_steps(4);
    check_eq("t2_strobes", strobes_seen, 3);
    check_eq("t2_blocks", blocks_written, 1);

    // 3: no buffer ready while in_valid is held
    do_reset();
    write_ready = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check_eq("t3_no_act", write_activate, 2'b00);
    check_eq("t3_no_rdy", in_ready, 1'b0);
    write_ready = 2'b10;
    step();
    check_eq("t3_grab1", write_activate, 2'b10);
    send_words(1, 1'b1);
    idle_steps(4);

    // 4: single-ready overrides alternation; both-ready alternates
    grab_log.delete();
    write_ready = 2'b01; send_words(1, 1'b1); idle_steps(4);
    write_ready = 2'b11; send_words(1, 1'b1); idle_steps(4);
    write_ready = 2'b01; send_words(1, 1'b1); idle_steps(4);
    check_eq("t4_ngrab", grab_log.size(), 3);
    if (grab_log.size() == 3) begin
      check_eq("t4_grab0", grab_log[0], 2'b01);
      check_eq("t4_grab1", grab_log[1], 2'b10);
      check_eq("t4_grab2", grab_log[2], 2'b01);
    end

    // 5: flush on an empty buffer is ignored; timeout after one word
    do_reset();
    write_ready = 2'b11; write_fifo_size = 24'd16;
    in_valid = 1'b1; step();
    in_valid = 1'b0; step();
    flush = 1'b1; step(); flush = 1'b0;
    idle_steps(30);
    check_eq("t5_flush_busy", busy, 1'b1);
    check_eq("t5_flush_blocks", blocks_written, 0);
    send_words(1, 1'b0);
    hold = 0;
    for (int i = 0; i < 60 && busy; i++) begin
      hold++;
      step();
    end
    check_eq("t5_hold", hold, TMO + 1);
    check_eq("t5_blocks", blocks_written, 1);

    // 6: reset in the middle of a buffer
    do_reset();
    write_fifo_size = 24'd16; write_ready = 2'b11;
    send_words(5, 1'b0);
    rst = 1'b1; in_valid = 1'b1; step();
    rst = 1'b0; in_valid = 1'b0;
    check_eq("t6_act", write_activate, 2'b00);
    check_eq("t6_busy", busy, 1'b0);
    check_eq("t6_strobe", write_strobe, 1'b0);
    check_eq("t6_blocks", blocks_written, 0);
    grab_log.delete();
    send_words(1, 1'b1); idle_steps(4);
    check_eq("t6_regrab", (grab_log.size() > 0) ? grab_log[0] : 2'b00, 2'b01);

    // Random traffic
    do_reset();
    pct = 70;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       pct = 10;
          1:       pct = 70;
          default: pct = 95;
        endcase
      end
      rst             = ($urandom_range(0, 299) == 0);
      in_valid        = ($urandom_range(0, 99) < pct);
      in_data         = DW'($urandom);
      in_last         = ($urandom_range(0, 9) == 0);
      flush           = ($urandom_range(0, 29) == 0);
      write_ready     = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      write_fifo_size = 24'($urandom_range(0, 6));
      step();
    end
    rst = 1'b0;
    idle_steps(40);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
